// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue scheduler and its testbench.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND    = 4'd0,
      OP_OR     = 4'd1,
      OP_NOT    = 4'd2,
      OP_ADD    = 4'd3,
      OP_SUB    = 4'd4,
      OP_INC    = 4'd5,
      OP_SHL    = 4'd6,
      OP_SHR    = 4'd7,
      OP_POPCNT = 4'd8
   } alu_op_e;

   localparam int ALU_LATENCY_C = 6;
   localparam int TAG_W_C       = 4;

   typedef struct packed {
      logic [63:0]        data;
      logic [TAG_W_C-1:0] tag;
      logic               err;
   } resp_t;

   // Opcodes above POPCNT have no ALU meaning and are issued as NOPs.
   function automatic logic opIsValid(input logic [3:0] op);
      return op <= 4'(OP_POPCNT);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy count.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [AW:0]      count_q;
   logic             doPush;
   logic             doPop;

   assign full   = (count_q == DEPTH_L);
   assign empty  = (count_q == '0);
   assign count  = count_q;
   assign dout   = mem_q[rdPtr_q];
   assign doPush = push & ~full;
   assign doPop  = pop & ~empty;

   // Storage array; contents are only meaningful between the pointers, so no reset.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + AW'(1);
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + AW'(1);
         end
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + (AW + 1)'(1);
            2'b01:   count_q <= count_q - (AW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_sched.sv
// Front-end for the no-backpressure pipelined ALU: issues tagged requests,
// pairs returning results with their tags and replays them in issue order.
module alu_issue_sched
   import alu_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int ALU_LATENCY = ALU_LATENCY_C,
   parameter int TAG_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [63:0]      req_a,
   input  logic [63:0]      req_b,
   input  logic [3:0]       req_op,
   input  logic [TAG_W-1:0] req_tag,
   output logic [63:0]      alu_a,
   output logic [63:0]      alu_b,
   output logic [3:0]       alu_op,
   output logic             alu_valid,
   input  logic [63:0]      alu_z,
   input  logic             alu_valid_o,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [63:0]      resp_data,
   output logic [TAG_W-1:0] resp_tag,
   output logic             resp_err,
   output logic             proto_err
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int BW = $clog2(ALU_LATENCY + 2);
   localparam int FW = 64 + TAG_W + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [BW-1:0] BLANK_C = BW'(ALU_LATENCY + 1);

   logic [CW-1:0]      cnt_q, cnt_d;
   logic [BW-1:0]      blank_q;
   logic               blank;
   logic               accept;
   logic               reqErr;
   logic               pop;
   logic               push;
   logic               lost;
   logic               protoHit;
   logic               finalVld;
   logic               protoErr_q;

   logic [63:0]        aluA_q, aluB_q;
   logic [3:0]         aluOp_q;
   logic               aluValid_q;

   logic [ALU_LATENCY:0] pipeVld_q;
   logic [ALU_LATENCY:0] pipeErr_q;
   logic [TAG_W-1:0]     pipeTag_q [ALU_LATENCY+1];

   logic [FW-1:0]      pushWord, headWord, respLast_q, respWord;
   logic               fifoFull, fifoEmpty;
   logic [$clog2(DEPTH):0] fifoCount;

   assign blank     = (blank_q != '0);
   assign req_ready = ~blank & (cnt_q < DEPTH_C);
   assign accept    = req_valid & req_ready;
   assign reqErr    = ~opIsValid(req_op);

   assign finalVld  = pipeVld_q[ALU_LATENCY];
   assign push      = finalVld & alu_valid_o;
   assign lost      = finalVld & ~alu_valid_o;
   assign protoHit  = ~blank & (finalVld ^ alu_valid_o);
   assign pushWord  = {pipeErr_q[ALU_LATENCY] ? 64'd0 : alu_z,
                       pipeTag_q[ALU_LATENCY], pipeErr_q[ALU_LATENCY]};

   assign pop        = ~fifoEmpty & resp_ready;
   assign resp_valid = ~fifoEmpty;
   assign respWord   = fifoEmpty ? respLast_q : headWord;
   assign resp_data  = respWord[FW-1 -: 64];
   assign resp_tag   = respWord[TAG_W:1];
   assign resp_err   = respWord[0];
   assign proto_err  = protoErr_q;

   assign alu_a     = aluA_q;
   assign alu_b     = aluB_q;
   assign alu_op    = aluOp_q;
   assign alu_valid = aluValid_q;

   // Hold off new work until stale ALU valid stages from before reset have drained.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blank_q <= BLANK_C;
      end else if (blank_q != '0) begin
         blank_q <= blank_q - BW'(1);
      end
   end

   // Credits cover every op in the ALU plus every buffered result; a slot lost
   // to a missing ALU response is handed back so the port cannot starve.
   always_comb begin
      cnt_d = cnt_q + CW'(accept) - CW'(pop) - CW'(lost);
   end

   // Credit counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Issue register: operands held when idle, invalid opcodes sent as a harmless AND.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aluA_q     <= '0;
         aluB_q     <= '0;
         aluOp_q    <= '0;
         aluValid_q <= 1'b0;
      end else begin
         aluValid_q <= accept;
         if (accept) begin
            aluA_q  <= req_a;
            aluB_q  <= req_b;
            aluOp_q <= reqErr ? 4'(OP_AND) : req_op;
         end
      end
   end

   // Tag pipe whose last stage lines up with alu_valid_o for the same op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipeVld_q <= '0;
         pipeErr_q <= '0;
         for (int i = 0; i <= ALU_LATENCY; i++) begin
            pipeTag_q[i] <= '0;
         end
      end else begin
         pipeVld_q    <= {pipeVld_q[ALU_LATENCY-1:0], accept};
         pipeErr_q    <= {pipeErr_q[ALU_LATENCY-1:0], accept & reqErr};
         pipeTag_q[0] <= accept ? req_tag : '0;
         for (int i = 1; i <= ALU_LATENCY; i++) begin
            pipeTag_q[i] <= pipeTag_q[i-1];
         end
      end
   end

   // Sticky protocol error: an ALU result with no owner or an owner with no result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         protoErr_q <= 1'b0;
      end else if (protoHit) begin
         protoErr_q <= 1'b1;
      end
   end

   // Remember the last popped entry so the response port holds steady when empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         respLast_q <= '0;
      end else if (pop) begin
         respLast_q <= headWord;
      end
   end

   sync_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) resultFifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (pushWord),
      .dout  (headWord),
      .full  (fifoFull),
      .empty (fifoEmpty),
      .count (fifoCount)
   );

   // The credit scheme must make overflow unreachable and bound buffered entries.
   assert property (@(posedge clk) disable iff (rst) !(push && fifoFull));
   assert property (@(posedge clk) disable iff (rst) fifoCount <= cnt_q);

endmodule

// File: tb/tb_alu_issue_sched.sv
// Self-checking bench for alu_issue_sched with a behavioural 6-stage ALU and a result scoreboard.
module tb_alu_issue_sched;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_a, req_b;
   logic [3:0]  req_op;
   logic [3:0]  req_tag;
   logic [63:0] alu_a, alu_b;
   logic [3:0]  alu_op;
   logic        alu_valid;
   logic [63:0] alu_z;
   logic        alu_valid_o;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_data;
   logic [3:0]  resp_tag;
   logic        resp_err;
   logic        proto_err;

   logic        injectVld = 1'b0;
   logic [5:0]  mdlVld = '0;
   logic [63:0] mdlZ [6];

   int    checks = 0;
   int    errors = 0;
   resp_t expQ [$];
   resp_t monExp;

   alu_issue_sched #(.DEPTH(8), .ALU_LATENCY(6), .TAG_W(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_valid(alu_valid),
      .alu_z(alu_z), .alu_valid_o(alu_valid_o),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_tag(resp_tag), .resp_err(resp_err),
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] refAlu(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] op);
      case (op)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return ~a;
         4'd3:    return a + b;
         4'd4:    return a - b;
         4'd5:    return a + 64'd1;
         4'd6:    return a << b[5:0];
         4'd7:    return a >> b[5:0];
         4'd8:    return 64'($countones(a));
         default: return 64'd0;
      endcase
   endfunction

   // ALU stand-in: six register stages, never reset, so stale valids survive a DUT reset.
   always @(posedge clk) begin
      mdlVld  <= {mdlVld[4:0], alu_valid};
      mdlZ[0] <= refAlu(alu_a, alu_b, alu_op);
      for (int i = 1; i < 6; i++) begin
         mdlZ[i] <= mdlZ[i-1];
      end
   end

   assign alu_z       = mdlZ[5];
   assign alu_valid_o = mdlVld[5] | injectVld;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Every popped response is compared against the oldest outstanding expectation.
   always @(negedge clk) begin
      #1;
      if (!rst && resp_valid && resp_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_resp", 64'(resp_valid), 64'd0);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("resp_data", resp_data, monExp.data);
            checkOutput("resp_tag", 64'(resp_tag), 64'(monExp.tag));
            checkOutput("resp_err", 64'(resp_err), 64'(monExp.err));
         end
      end
   end

   task automatic applyReset();
      rst       = 1'b1;
      req_valid = 1'b0;
      expQ.delete();
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
      checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
      checkOutput("rst_alu_valid", 64'(alu_valid), 64'd0);
      checkOutput("rst_proto_err", 64'(proto_err), 64'd0);
      checkOutput("rst_resp_data", resp_data, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         #1 checkOutput("blank_ready", 64'(req_ready), 64'd0);
         @(negedge clk);
      end
      #1 checkOutput("ready_after_blank", 64'(req_ready), 64'd1);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                                input logic [3:0] tag, input logic [63:0] expData,
                                input logic expErr);
      int waitCyc = 0;
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_op    = op;
      req_tag   = tag;
      while (!req_ready && waitCyc < 40) begin
         @(negedge clk);
         waitCyc++;
      end
      if (!req_ready) begin
         checkOutput("accept_timeout", 64'(req_ready), 64'd1);
      end else begin
         expQ.push_back('{data: expData, tag: tag, err: expErr});
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while (expQ.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checkOutput("drain", 64'(expQ.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int idx;
      int accepted;
      logic [63:0] ra, rb;
      logic [3:0]  rop;

      req_valid  = 1'b0;
      req_a      = '0;
      req_b      = '0;
      req_op     = '0;
      req_tag    = '0;
      resp_ready = 1'b1;
      applyReset();

      // Single ADD and its issue-to-response latency.
      applyStimulus(64'd5, 64'd7, 4'(OP_ADD), 4'd3, 64'd12, 1'b0);
      lat = 0;
      while (!resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("latency", 64'(lat), 64'd7);
      waitDrain(20);

      // Fill every credit with no consumer, then release.
      resp_ready = 1'b0;
      idx        = 0;
      accepted   = 0;
      for (int c = 0; c < 20; c++) begin
         if (idx < 10) begin
            req_valid = 1'b1;
            req_a     = 64'(idx * 3);
            req_b     = 64'(idx + 100);
            req_op    = 4'(OP_ADD);
            req_tag   = 4'(idx);
         end else begin
            req_valid = 1'b0;
         end
         #1;
         if (req_valid && req_ready) begin
            expQ.push_back('{data: 64'(idx * 3 + idx + 100), tag: 4'(idx), err: 1'b0});
            idx++;
            accepted++;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      checkOutput("burst_accepts", 64'(accepted), 64'd8);
      checkOutput("burst_ready_low", 64'(req_ready), 64'd0);
      resp_ready = 1'b1;
      #1 checkOutput("ready_before_pop", 64'(req_ready), 64'd0);
      @(negedge clk);
      #1 checkOutput("ready_after_pop", 64'(req_ready), 64'd1);
      waitDrain(40);

      // POPCNT and SHL with an oversized shift amount.
      applyStimulus(64'hFF00_FF00_0000_000F, 64'd0, 4'(OP_POPCNT), 4'd1, 64'd20, 1'b0);
      applyStimulus(64'd1, 64'd70, 4'(OP_SHL), 4'd2, 64'd64, 1'b0);
      waitDrain(30);

      // Invalid opcode comes back flagged with zero data.
      applyStimulus(64'h1234, 64'd5, 4'd12, 4'd9, 64'd0, 1'b1);
      waitDrain(30);
      checkOutput("proto_after_bad_op", 64'(proto_err), 64'd0);

      // Mixed traffic with occasional idle cycles.
      for (int i = 0; i < 12; i++) begin
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom};
         rop = 4'($urandom_range(0, 8));
         applyStimulus(ra, rb, rop, 4'(i), refAlu(ra, rb, rop), 1'b0);
         if ($urandom_range(0, 2) == 0) @(negedge clk);
      end
      waitDrain(60);

      // Reset with three ops in the ALU and two results buffered.
      resp_ready = 1'b0;
      applyStimulus(64'd1, 64'd2, 4'(OP_ADD), 4'd1, 64'd3, 1'b0);
      applyStimulus(64'd3, 64'd4, 4'(OP_ADD), 4'd2, 64'd7, 1'b0);
      repeat (2) @(negedge clk);
      applyStimulus(64'd5, 64'd6, 4'(OP_ADD), 4'd3, 64'd11, 1'b0);
      applyStimulus(64'd7, 64'd8, 4'(OP_ADD), 4'd4, 64'd15, 1'b0);
      applyStimulus(64'd9, 64'd1, 4'(OP_ADD), 4'd5, 64'd10, 1'b0);
      repeat (2) @(negedge clk);
      #1 checkOutput("pre_rst_buffered", 64'(resp_valid), 64'd1);
      @(negedge clk);
      resp_ready = 1'b1;
      applyReset();
      repeat (15) @(negedge clk);
      #1;
      checkOutput("post_rst_no_resp", 64'(resp_valid), 64'd0);
      checkOutput("post_rst_proto", 64'(proto_err), 64'd0);
      @(negedge clk);

      // Spurious ALU result with nothing expected.
      #1 checkOutput("proto_before_inject", 64'(proto_err), 64'd0);
      @(negedge clk);
      injectVld = 1'b1;
      @(negedge clk);
      injectVld = 1'b0;
      #1;
      checkOutput("proto_set", 64'(proto_err), 64'd1);
      checkOutput("proto_fifo_empty", 64'(resp_valid), 64'd0);
      repeat (3) @(negedge clk);
      #1 checkOutput("proto_sticky", 64'(proto_err), 64'd1);

      checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
